// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : univ_shift_reg_if                                        |
// | Description : Control/data bundle for univ_shift_reg. The master       |
// |               drives enable, mode, parallel and serial inputs; the     |
// |               slave (the register) returns its contents, serial taps   |
// |               and frame-counter status.                                |
// | Ports       : en, mode[2:0], in_data[WIDTH], ser_in_l, ser_in_r        |
// |               out_data[WIDTH], ser_out_msb, ser_out_lsb,               |
// |               shift_cnt[CNT_W], frame_done                             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] in_data;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] out_data;
  logic             ser_out_msb;
  logic             ser_out_lsb;
  logic [CNT_W-1:0] shift_cnt;
  logic             frame_done;

  modport master (
    output en, mode, in_data, ser_in_l, ser_in_r,
    input  out_data, ser_out_msb, ser_out_lsb, shift_cnt, frame_done
  );

  modport slave (
    input  en, mode, in_data, ser_in_l, ser_in_r,
    output out_data, ser_out_msb, ser_out_lsb, shift_cnt, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : univ_shift_reg                                           |
// | Description : Parametrised universal shift register with clock enable. |
// |               Modes: HOLD, SHL, SHR, ROTL, ROTR, LOAD, ASR, CLR.       |
// |               Optional frame counter (macro USR_FRAME_CNT_EN) counts   |
// |               shifts since the last LOAD/CLR and pulses frame_done     |
// |               for one cycle after every WIDTH-th shift. Without the    |
// |               macro, shift_cnt and frame_done are tied to 0.           |
// | Ports       : clk   - rising-edge clock                                |
// |               reset - asynchronous reset, active low                   |
// |               bus   - univ_shift_reg_if.slave (en, mode, in_data,      |
// |                       ser_in_l/r in; out_data, ser_out_msb/lsb,        |
// |                       shift_cnt, frame_done out)                       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module univ_shift_reg #(
  parameter int WIDTH = 8  // must match the WIDTH of the connected interface
) (
  input  wire logic            clk,
  input  wire logic            reset,
  univ_shift_reg_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROTL = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  always_comb begin
    w_q_next = r_q;
    case (bus.mode)
      MODE_HOLD: w_q_next = r_q;
      MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], bus.ser_in_l};
      MODE_SHR:  w_q_next = {bus.ser_in_r, r_q[WIDTH-1:1]};
      MODE_ROTL: w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_ROTR: w_q_next = {r_q[0], r_q[WIDTH-1:1]};
      MODE_LOAD: w_q_next = bus.in_data;
      MODE_ASR:  w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      MODE_CLR:  w_q_next = '0;
      default:   w_q_next = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (bus.en) begin
      r_q <= w_q_next;
    end
  end

  assign bus.out_data    = r_q;
  assign bus.ser_out_msb = r_q[WIDTH-1];
  assign bus.ser_out_lsb = r_q[0];

`ifdef USR_FRAME_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_done;
  logic             w_shift;
  logic             w_restart;

  assign w_shift   = (bus.mode == MODE_SHL)  || (bus.mode == MODE_SHR) ||
                     (bus.mode == MODE_ROTL) || (bus.mode == MODE_ROTR) ||
                     (bus.mode == MODE_ASR);
  assign w_restart = (bus.mode == MODE_LOAD) || (bus.mode == MODE_CLR);

  // frame_done defaults low every cycle so it can only ever be a one-cycle
  // pulse, including when frames run back to back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (bus.en) begin
        if (w_restart) begin
          r_cnt <= '0;
        end else if (w_shift) begin
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.shift_cnt  = r_cnt;
  assign bus.frame_done = r_frame_done;
`else
  assign bus.shift_cnt  = '0;
  assign bus.frame_done = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the successor to the fixed 8-bit parallel-in/parallel-out register. Adds a clock enable and eight operating modes: hold, logical shifts, rotates, arithmetic shift, parallel load and clear. Serial inputs and outputs sit at both ends of the register. An optional frame counter flags each completed WIDTH-bit serial frame. It sits in the shift-register library as the general building block for SIPO, PISO, PIPO and barrel-style data paths.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH), frame counter width (derived; do not override).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Reset is asserted when low.
- en  input  1  clock enable; when low, all state holds.
- mode  input  3  operation select (see Operation).
- in_data  input  WIDTH  parallel load value.
- ser_in_l  input  1  serial bit entering bit 0 on a left shift.
- ser_in_r  input  1  serial bit entering bit WIDTH-1 on a right shift.
- out_data  output  WIDTH  register contents.
- ser_out_msb  output  1  equals out_data[WIDTH-1].
- ser_out_lsb  output  1  equals out_data[0].
- shift_cnt  output  CNT_W  shifts since last load/clear (frame counter build only).
- frame_done  output  1  one-cycle pulse on frame completion (frame counter build only).

## Operation
- mode 000 HOLD: q unchanged.
- mode 001 SHL: q ← {q[WIDTH-2:0], ser_in_l}.
- mode 010 SHR: q ← {ser_in_r, q[WIDTH-1:1]}.
- mode 011 ROTL: q ← {q[WIDTH-2:0], q[WIDTH-1]}.
- mode 100 ROTR: q ← {q[0], q[WIDTH-1:1]}.
- mode 101 LOAD: q ← in_data.
- mode 110 ASR: q ← {q[WIDTH-1], q[WIDTH-1:1]}; the sign bit is replicated.
- mode 111 CLR: q ← 0.
- en=0 overrides mode. Register and counter hold; frame_done is 0.
- ser_out_msb and ser_out_lsb are combinational taps of q, with no extra register.
- Shift-class modes are 001, 010, 011, 100 and 110.
- Frame counter:
  - LOAD and CLR set shift_cnt to 0.
  - Each enabled shift-class cycle increments shift_cnt.
  - The shift taking shift_cnt from WIDTH-1 wraps it to 0 and sets frame_done for the following cycle.
  - HOLD leaves the count unchanged.
- Reset mid-operation: q, shift_cnt and frame_done clear immediately, independent of clk. Operation resumes on the first rising edge after reset deasserts.

## Timing
- Reset values: out_data=0, ser_out_msb=0, ser_out_lsb=0, shift_cnt=0, frame_done=0.
- Latency: one clock. Mode and data sampled at edge N appear on out_data after edge N.
- frame_done is registered.
  - It is high for exactly one cycle after the edge of the WIDTH-th shift.
  - It is 0 in every other cycle, including back-to-back frames between their final shifts.
- No handshake. en is the only qualifier; every enabled edge executes mode.
- Reset deassertion must meet recovery/removal timing against clk. Synchronising reset is the integrator's job.

## Configuration
- Macro USR_FRAME_CNT_EN.
  - Defined: shift_cnt and frame_done are built as described above.
  - Undefined: the counter logic is omitted. shift_cnt is tied to 0, frame_done is tied to 0, and the ports remain present.

## Test plan
- Reset: drive reset=0 mid-cycle with q=8'hA5 → out_data=8'h00 before the next edge; shift_cnt=0; frame_done=0.
- Load/hold: LOAD in_data=8'hF0, then HOLD for 3 cycles, then en=0 with mode=001 → out_data stays 8'hF0 throughout.
- Shifts, from q=8'hB4:
  - SHL with ser_in_l=1 → 8'h69.
  - SHR with ser_in_r=0 → 8'h5A.
  - ASR on 8'hB4 → 8'hDA.
- Rotates: ROTL on 8'h81 → 8'h03. ROTR on 8'h81 → 8'hC0. ser_out_msb and ser_out_lsb track q each cycle.
- SIPO frame (USR_FRAME_CNT_EN defined): CLR, then 8 SHL with ser_in_l bits 1,0,1,0,1,0,1,0 → out_data=8'hAA and frame_done high for exactly 1 cycle. A continued 8-shift run gives a second single pulse. With the macro undefined, frame_done stays 0.
- Counter restart: 5 shifts, then LOAD 8'h3C → shift_cnt returns to 0; frame_done pulses only after 8 further shifts.
